// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: writes accepted bytes at
// addresses 0..len-1, keeps a running checksum and stalls the core until done.
module imem_loader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  we_imem,
  output logic [ADDR_WIDTH-1:0] w_addr_imem,
  output logic [7:0]            w_data_imem,
  output logic [7:0]            checksum,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cpu_hold
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [TW-1:0]       TMAX    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH-1:0] count;
  logic [TW-1:0]         timer;
  logic                  accept;
  logic                  len_bad;
  logic                  last_byte;

  assign s_ready   = (state == LOAD);
  assign accept    = s_valid && s_ready;
  assign len_bad   = (len == '0) || (len > DEPTH_L);
  assign last_byte = ({1'b0, count} == (len_q - 1'b1));

  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign err      = (state == ERROR);
  assign cpu_hold = (state != DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      count       <= '0;
      timer       <= '0;
      we_imem     <= 1'b0;
      w_addr_imem <= '0;
      w_data_imem <= '0;
      checksum    <= '0;
    end else begin
      // write strobe is a one-cycle pulse; address/data hold between writes
      we_imem <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            if (len_bad) begin
              state <= ERROR;
            end else begin
              state    <= LOAD;
              len_q    <= len;
              count    <= '0;
              checksum <= '0;
              timer    <= '0;
            end
          end
        end
        LOAD: begin
          // an accept on the expiry cycle wins over the timeout
          if (accept) begin
            we_imem     <= 1'b1;
            w_addr_imem <= count;
            w_data_imem <= s_data;
            count       <= count + 1'b1;
            checksum    <= checksum + s_data;
            timer       <= '0;
            if (last_byte) state <= DONE;
          end else if (timer == TMAX) begin
            state <= ERROR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued at accept time
// and a negedge monitor compares every we_imem pulse against the queue.
module tb_imem_loader;

  localparam int AW = 7;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   len;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          we_imem;
  logic [AW-1:0] w_addr_imem;
  logic [7:0]    w_data_imem;
  logic [7:0]    checksum;
  logic          busy, done, err, cpu_hold;

  int vectors = 0;
  int miscompares = 0;
  logic [14:0] exp_q[$];

  imem_loader #(.ADDR_WIDTH(AW), .DEPTH(128), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .we_imem(we_imem), .w_addr_imem(w_addr_imem), .w_data_imem(w_data_imem),
    .checksum(checksum), .busy(busy), .done(done), .err(err),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor
  initial begin
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (we_imem === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                   w_addr_imem, w_data_imem);
        end else begin
          e = exp_q.pop_front();
          if ({w_addr_imem, w_data_imem} !== e) begin
            miscompares++;
            $display("FAIL write: addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                     w_addr_imem, w_data_imem, e[14:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic do_start(input int l);
    start = 1'b1;
    len   = (AW + 1)'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers a byte, waits for the accept edge, returns #1 after it.
  task automatic send_byte(input logic [7:0] d, input logic [AW-1:0] addr);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: s_ready=0, expected 1 within 100 cycles");
    end else begin
      exp_q.push_back({addr, d});
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, we_imem, 0);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_flags"}, {busy, done, err}, 3'b000);
    chk({tag, "_hold"}, cpu_hold, 1);
    chk({tag, "_csum"}, checksum, 8'h00);
  endtask

  logic [7:0] t2 [4] = '{8'h13, 8'h00, 8'h00, 8'h00};

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
    // 1: reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_reset_vals("rst");
    chk("rst_addr", {w_addr_imem, w_data_imem}, 0);

    // 2: four back-to-back bytes
    do_start(4);
    chk("t2_busy", busy, 1);
    for (int i = 0; i < 4; i++) send_byte(t2[i], AW'(i));
    chk("t2_done", done, 1);
    chk("t2_hold", cpu_hold, 0);
    chk("t2_we_last", we_imem, 1);
    chk("t2_csum", checksum, 8'h13);
    @(posedge clk); #1;

    // 3: full memory with gaps
    do_start(128);
    for (int i = 0; i < 128; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1 send_byte(8'(i), AW'(i));
    end
    chk("t3_last_addr", w_addr_imem, 7'd127);
    chk("t3_last_data", w_data_imem, 8'h7F);
    chk("t3_done", done, 1);
    chk("t3_csum", checksum, 8'hC0);
    @(posedge clk); #1;

    // 4: illegal lengths, then recovery
    do_start(0);
    chk("t4_err0", err, 1);
    chk("t4_ready0", s_ready, 0);
    do_start(129);
    chk("t4_err129", err, 1);
    chk("t4_ready129", s_ready, 0);
    chk("t4_hold", cpu_hold, 1);
    do_start(1);
    send_byte(8'hAA, 7'd0);
    chk("t4_done", done, 1);
    chk("t4_csum", checksum, 8'hAA);
    @(posedge clk); #1;

    // 5: timeout after one byte
    do_start(2);
    send_byte(8'h55, 7'd0);
    repeat (15) @(posedge clk);
    #1 chk("t5_not_yet", {busy, err}, 2'b10);
    @(posedge clk); #1;
    chk("t5_err", err, 1);
    chk("t5_hold", cpu_hold, 1);
    chk("t5_ready", s_ready, 0);
    chk("t5_csum", checksum, 8'h55);

    // 6: reset in the middle of a load
    do_start(8);
    send_byte(8'h01, 7'd0);
    send_byte(8'h02, 7'd1);
    rst_n = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hEE;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_valid = 1'b0;
    chk_reset_vals("t6");
    repeat (3) @(posedge clk);
    #1 do_start(1);
    send_byte(8'h3C, 7'd0);
    chk("t6_done", done, 1);
    chk("t6_csum", checksum, 8'h3C);

    repeat (3) @(posedge clk);
    #1 chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream programmer that fills the byte-addressed instruction memory before the RV32I core runs. It accepts bytes over a valid/ready stream, issues one byte write per accepted byte at incrementing addresses starting at 0, and keeps a running checksum. It holds the core stalled until a load completes successfully. It sits between a host link (e.g. a UART receiver) and the write port of a writable variant of the instruction memory.

Parameters:
ADDR_WIDTH, 7, byte address width of instruction memory
DEPTH, 128, memory size in bytes (equals 2**ADDR_WIDTH)
TIMEOUT, 1024, max consecutive LOAD cycles without an accepted byte before abort (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin load; sampled only in IDLE, DONE, ERROR
len  input  ADDR_WIDTH+1  byte count for this load, latched on start; legal 1..DEPTH
s_valid  input  1  stream byte valid
s_data  input  8  stream byte
s_ready  output  1  loader accepts byte this cycle
we_imem  output  1  byte write enable to instruction memory
w_addr_imem  output  ADDR_WIDTH  byte write address
w_data_imem  output  8  byte write data
checksum  output  8  sum of accepted bytes mod 256
busy  output  1  high in LOAD
done  output  1  high in DONE
err  output  1  high in ERROR
cpu_hold  output  1  stall/reset request to core; low only in DONE

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; we_imem=0, w_addr_imem=0, w_data_imem=0, checksum=0, busy=0, done=0, err=0, cpu_hold=1; internal counters cleared. Takes priority over all other events, including mid-load; no further writes after the reset edge.
- States: IDLE, LOAD, DONE, ERROR. busy/done/err are decoded from state; cpu_hold = (state != DONE).
- IDLE/DONE/ERROR, start=1: if len==0 or len>DEPTH -> ERROR. Otherwise -> LOAD; latch len, byte counter=0, checksum=0, idle timer=0. start=0: stay.
- LOAD: s_ready=1 (combinational from state). In all other states s_ready=0. start ignored.
- Accept = s_valid && s_ready at a clock edge. On accept: next cycle we_imem=1, w_addr_imem=counter, w_data_imem=s_data (one-cycle registered latency). counter+1, checksum+=s_data (8-bit wrap), idle timer=0.
- we_imem is a single-cycle pulse per accepted byte. Back-to-back accepts give consecutive write cycles. w_addr_imem/w_data_imem hold their last values when we_imem=0.
- Accept of the final byte (counter==len-1) -> DONE. The write for that byte appears in the first DONE cycle. Addresses never exceed DEPTH-1, so no wrap.
- LOAD, no accept: idle timer+1. If timer reaches TIMEOUT-1 and no accept occurs that cycle -> ERROR. An accept in the same cycle the timer would expire wins: the timer resets and the state stays in LOAD.
- ERROR: err=1, cpu_hold=1; memory contents are partial and undefined for the core. checksum holds its value. Leave only via start or reset.
- DONE: done=1, cpu_hold=0, checksum stable until the next start.

Test Plan:
1. Hold rst_n low 2 cycles -> we_imem=0, s_ready=0, busy/done/err=0, cpu_hold=1, checksum=0x00.
2. start with len=4, then bytes 0x13,0x00,0x00,0x00 back-to-back -> 4 consecutive we_imem pulses at addr 0,1,2,3 with matching data, each one cycle after its accept; checksum=0x13; done=1 and cpu_hold=0 in the cycle of the last write.
3. start with len=128, data byte = index, random s_valid gaps shorter than TIMEOUT -> 128 writes, last at addr 127 with data 0x7F; checksum=0xC0; done=1.
4. start with len=0, and separately len=129 -> err=1 the cycle after start; s_ready stays 0; no writes. A following start with len=1 and byte 0xAA -> write to addr 0, done=1.
5. TIMEOUT=16, start with len=2, send one byte then hold s_valid=0 -> exactly one write (addr 0); err=1 after 16 LOAD cycles without an accepted byte; cpu_hold=1.
6. start with len=8, accept 2 bytes, then pull rst_n low for one cycle -> all outputs at reset values, no write after the reset edge. A new start with len=1 completes normally.
